// File: rtl/subfield_norm_serial.sv
// Bit-serial norm stage ahead of the GF((2^2)^2) subfield inverter:
// D = Ah*X ^ Al^2 with X = lambda*Ah ^ Al, Ah*X formed over 4 shift-and-add cycles.
module subfield_norm_serial #(
    parameter logic [3:0] LAMBDA = 4'h8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_d,
    output logic [3:0] out_ah,
    output logic [3:0] out_al,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] ah_q, ah_d;
    logic [3:0] al_q, al_d;
    logic [3:0] x_q, x_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] d_q, d_d;
    logic [1:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       accept;
    logic [3:0] acc_next;

    function automatic logic [3:0] xtime(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    // Squaring is linear over GF(2): a^2 = a0 + a1 x^2 + a2 (x+1) + a3 (x^3+x^2).
    function automatic logic [3:0] gf_sq(input logic [3:0] a);
        return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
    endfunction

    function automatic logic [3:0] mul_lambda(input logic [3:0] a);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            r = xtime(r);
            if (LAMBDA[3 - i]) r = r ^ a;
        end
        return r;
    endfunction

    assign accept   = in_valid & in_ready;
    assign acc_next = xtime(acc_q) ^ (ah_q[cnt_q] ? x_q : 4'h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ah_q    <= '0;
            al_q    <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ah_q    <= ah_d;
            al_q    <= al_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ah_d    = ah_q;
        al_d    = al_q;
        x_d     = x_q;
        acc_d   = acc_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        case (state_q)
            MUL: begin
                if (cnt_q != 2'd0) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    d_d     = acc_next ^ gf_sq(al_q);
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Acceptance in IDLE and the consume-and-accept case in DONE share one load path.
        if (accept) begin
            ah_d    = in_data[7:4];
            al_d    = in_data[3:0];
            x_d     = mul_lambda(in_data[7:4]) ^ in_data[3:0];
            acc_d   = '0;
            cnt_d   = 2'd3;
            state_d = MUL;
        end
    end

    always_comb begin
        in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
        busy      = (state_q == MUL);
        out_valid = valid_q;
        out_d     = d_q;
        out_ah    = ah_q;
        out_al    = al_q;
    end

endmodule

// File: tb/tb_subfield_norm_serial.sv
// Bench for subfield_norm_serial: a handshake/timing model and a GF(2^4) norm model
// are checked every cycle, alongside directed, streaming and random-stall sequences.
module tb_subfield_norm_serial;

    localparam logic [3:0] LAMBDA = 4'h8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_d;
    logic [3:0] out_ah;
    logic [3:0] out_al;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_results = 0;
    int unsigned n_zero    = 0;

    subfield_norm_serial #(.LAMBDA(LAMBDA)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_ah    (out_ah),
        .out_al    (out_al),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full carry-less product followed by reduction mod x^4+x+1.
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ ({4'b0, a} << i);
        for (int i = 7; i >= 4; i--)
            if (p[i]) p = p ^ (8'h13 << (i - 4));
        return p[3:0];
    endfunction

    function automatic logic [3:0] model_d(input logic [7:0] b);
        logic [3:0] ah, al;
        ah = b[7:4];
        al = b[3:0];
        return gmul(LAMBDA, gmul(ah, ah)) ^ gmul(ah, al) ^ gmul(al, al);
    endfunction

    // Handshake model: an accepted byte is in flight for 4 edges, then held until consumed.
    bit         m_inflight = 0;
    bit         m_have     = 0;
    int         m_timer    = 0;
    logic [7:0] m_byte_in  = '0;
    logic [7:0] m_byte_out = '0;

    always @(negedge clk) begin
        bit exp_ready;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            m_inflight = 0;
            m_have     = 0;
            m_timer    = 0;
        end else begin
            exp_ready = !m_inflight && (!m_have || out_ready);
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, m_have);
            chk("busy", busy, m_inflight);
            if (m_have) begin
                chk("out_d", out_d, model_d(m_byte_out));
                chk("out_ah", out_ah, m_byte_out[7:4]);
                chk("out_al", out_al, m_byte_out[3:0]);
                if (out_ready) begin
                    n_results++;
                    if (out_d == 4'h0) n_zero++;
                end
            end
            if (m_have && out_ready) m_have = 0;
            if (m_inflight) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_inflight = 0;
                    m_have     = 1;
                    m_byte_out = m_byte_in;
                end
            end
            if (in_valid && exp_ready) begin
                m_inflight = 1;
                m_timer    = 4;
                m_byte_in  = in_data;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic accept_byte(input logic [7:0] b);
        bit got;
        got      = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called just after the acceptance edge; returns on the negedge where out_valid is seen.
    task automatic wait_valid(output int lat, output int nbusy);
        bit got;
        got   = 0;
        lat   = 0;
        nbusy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                break;
            end
            lat++;
            if (busy) nbusy++;
        end
        if (!got) chk("valid_timeout", 0, 1);
    endtask

    logic [7:0] basic_b [5] = '{8'h00, 8'h01, 8'h10, 8'h23, 8'h57};
    logic [3:0] basic_e [5] = '{4'h0, 4'h1, 4'h8, 4'h5, 4'hD};

    initial begin
        int lat, nb, nvalid, w, bad_gap, accepted, cyc;
        int unsigned r0, z0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_d", out_d, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 1);

        chk("model_pin_57", model_d(8'h57), 4'hD);
        chk("model_pin_23", model_d(8'h23), 4'h5);
        chk("model_pin_10", model_d(8'h10), 4'h8);

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            accept_byte(basic_b[i]);
            wait_valid(lat, nb);
            chk("basic_d", out_d, basic_e[i]);
            if (i == 4) begin
                chk("latency_57", lat, 4);
                chk("busy_cycles_57", nb, 4);
                chk("basic_ah_57", out_ah, 4'h5);
                chk("basic_al_57", out_al, 4'h7);
            end
        end

        // Backpressure with a pending byte held on the input.
        @(posedge clk);
        #1 out_ready = 1'b0;
        accept_byte(8'h57);
        wait_valid(lat, nb);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h23;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_d", out_d, 4'hD);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat, nb);
        chk("bp_latency", lat, 4);
        chk("bp_next_d", out_d, 4'h5);

        // Reset in the middle of a multiply.
        @(posedge clk);
        #1;
        accept_byte(8'h57);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_d", out_d, 0);
        chk("midrst_out_ah", out_ah, 0);
        chk("midrst_out_al", out_al, 0);
        chk("midrst_in_ready", in_ready, 1);
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) nvalid++;
        end
        chk("midrst_no_stale", nvalid, 0);

        // Back-to-back streaming of every byte value.
        @(posedge clk);
        #1;
        r0        = n_results;
        z0        = n_zero;
        bad_gap   = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!in_ready && w < 20);
            if (!in_ready) begin
                chk("stream_timeout", 0, 1);
                break;
            end
            if (i > 0 && w != 5) bad_gap++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("stream_gaps", bad_gap, 0);
        chk("stream_results", n_results - r0, 256);
        chk("stream_zero_count", n_zero - z0, 1);

        // Random valid/ready stalls.
        accepted = 0;
        cyc      = 0;
        while (accepted < 2000 && cyc < 40000) begin
            out_ready = 1'($urandom % 2);
            in_valid  = 1'($urandom % 2);
            in_data   = 8'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) accepted++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("random_all_accepted", (accepted >= 2000) ? 1 : 0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
